// File: rtl/dma_rd_arbiter.sv
// dma_rd_arbiter: single-outstanding AXI read arbiter sharing one ariane_axi read port among NUM_REQ pollers.
// Define DMA_RD_ARB_FIXED_PRIO_EN for fixed lowest-index priority instead of round robin.
package ariane_axi;
   typedef struct packed {
      logic [3:0]  id;
      logic [63:0] addr;
      logic [7:0]  len;
      logic [2:0]  size;
      logic [1:0]  burst;
      logic        lock;
      logic [3:0]  cache;
      logic [2:0]  prot;
      logic [3:0]  qos;
      logic [3:0]  region;
   } ax_chan_t;
   typedef struct packed {
      logic [63:0] data;
      logic [7:0]  strb;
      logic        last;
   } w_chan_t;
   typedef struct packed {
      logic [3:0] id;
      logic [1:0] resp;
   } b_chan_t;
   typedef struct packed {
      logic [3:0]  id;
      logic [63:0] data;
      logic [1:0]  resp;
      logic        last;
   } r_chan_t;
   typedef struct packed {
      ax_chan_t aw;
      logic     aw_valid;
      w_chan_t  w;
      logic     w_valid;
      logic     b_ready;
      ax_chan_t ar;
      logic     ar_valid;
      logic     r_ready;
   } req_t;
   typedef struct packed {
      logic    aw_ready;
      logic    ar_ready;
      logic    w_ready;
      logic    b_valid;
      b_chan_t b;
      logic    r_valid;
      r_chan_t r;
   } resp_t;
endpackage

module dma_rd_arbiter #(
   parameter int unsigned NUM_REQ = 2,
   parameter int unsigned AXI_ID  = 1
) (
   input  logic                  clk_i,
   input  logic                  rst_i,
   input  logic [NUM_REQ-1:0]    req_valid_i,
   input  logic [NUM_REQ*64-1:0] req_addr_i,
   output logic [NUM_REQ-1:0]    req_ready_o,
   output logic [NUM_REQ-1:0]    rsp_valid_o,
   output logic [63:0]           rsp_data_o,
   output logic                  rsp_err_o,
   output logic                  busy_o,
   output ariane_axi::req_t      axi_req_o,
   input  ariane_axi::resp_t     axi_resp_i
);
   localparam int unsigned IW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
   typedef enum logic [1:0] {IDLE, AR, R, RESP} state_t;
   state_t             r_state, w_next;
   logic [IW-1:0]      r_owner, w_win;
   logic               w_any, w_ar_hs, w_r_hs, w_unused;
   logic [63:0]        w_addr, r_addr, r_data;
   logic [NUM_REQ-1:0] r_req_ready, r_rsp_valid;
   logic [1:0]         r_burst;
   logic               r_err, r_ar_valid, r_r_ready, r_busy;
`ifndef DMA_RD_ARB_FIXED_PRIO_EN
   logic [IW-1:0]      r_ptr;
`endif
   assign w_any   = |req_valid_i;
   assign w_ar_hs = r_ar_valid & axi_resp_i.ar_ready;
   assign w_r_hs  = r_r_ready & axi_resp_i.r_valid;
   // Candidates are scanned from lowest to highest priority so the winner is assigned last.
   always_comb begin
      w_win  = '0;
      w_addr = '0;
`ifdef DMA_RD_ARB_FIXED_PRIO_EN
      for (int k = NUM_REQ - 1; k >= 0; k--)
         if (req_valid_i[k]) w_win = IW'(k);
`else
      for (int i = NUM_REQ - 1; i >= 0; i--)
         for (int k = 0; k < NUM_REQ; k++)
            if (req_valid_i[k] && k == (int'(r_ptr) + i) % NUM_REQ) w_win = IW'(k);
`endif
      for (int k = 0; k < NUM_REQ; k++)
         if (w_win == IW'(k)) w_addr = req_addr_i[64*k +: 64];
   end
   always_comb begin
      w_next = r_state;
      case (r_state)
         IDLE:    w_next = w_any ? AR : IDLE;
         AR:      w_next = w_ar_hs ? R : AR;
         R:       w_next = w_r_hs ? RESP : R;
         default: w_next = IDLE;
      endcase
   end
   always_ff @(posedge clk_i or posedge rst_i)
      if (rst_i) r_state <= IDLE;
      else       r_state <= w_next;
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         r_owner     <= '0;
         r_addr      <= '0;
         r_data      <= '0;
         r_err       <= 1'b0;
         r_burst     <= 2'b00;
         r_req_ready <= '0;
         r_rsp_valid <= '0;
         r_ar_valid  <= 1'b0;
         r_r_ready   <= 1'b0;
         r_busy      <= 1'b0;
`ifndef DMA_RD_ARB_FIXED_PRIO_EN
         r_ptr       <= '0;
`endif
      end else begin
         r_burst     <= 2'b01;
         r_ar_valid  <= w_next == AR;
         r_r_ready   <= w_next == R;
         r_busy      <= w_next != IDLE;
         r_req_ready <= '0;
         r_rsp_valid <= '0;
         if (r_state == IDLE && w_any) begin
            r_owner     <= w_win;
            r_addr      <= {w_addr[63:3], 3'b000};
            r_req_ready <= NUM_REQ'(1) << w_win;
         end
         if (w_r_hs) begin
            r_data      <= axi_resp_i.r.data;
            r_err       <= axi_resp_i.r.resp != 2'b00;
            r_rsp_valid <= NUM_REQ'(1) << r_owner;
         end
`ifndef DMA_RD_ARB_FIXED_PRIO_EN
         if (r_state == RESP) r_ptr <= (r_owner == IW'(NUM_REQ - 1)) ? '0 : r_owner + 1'b1;
`endif
      end
   end
   always_comb begin
      axi_req_o          = '0;
      axi_req_o.ar.id    = 4'(AXI_ID);
      axi_req_o.ar.addr  = r_addr;
      axi_req_o.ar.size  = 3'd3;
      axi_req_o.ar.burst = r_burst;
      axi_req_o.ar_valid = r_ar_valid;
      axi_req_o.r_ready  = r_r_ready;
   end
   assign req_ready_o = r_req_ready;
   assign rsp_valid_o = r_rsp_valid;
   assign rsp_data_o  = r_data;
   assign rsp_err_o   = r_err;
   assign busy_o      = r_busy;
   // Single beat, single outstanding: write channels, r.id and r.last carry no information here.
   assign w_unused = ^{axi_resp_i.aw_ready, axi_resp_i.w_ready, axi_resp_i.b_valid, axi_resp_i.b,
                       axi_resp_i.r.id, axi_resp_i.r.last, w_addr[2:0]};
endmodule

// File: tb/tb_dma_rd_arbiter.sv
// tb_dma_rd_arbiter: directed checks of grant, AR/R sequencing, backpressure, errors and reset for dma_rd_arbiter.
module tb_dma_rd_arbiter;
`ifdef DMA_RD_ARB_FIXED_PRIO_EN
   localparam bit FIXED = 1'b1;
`else
   localparam bit FIXED = 1'b0;
`endif
   logic              clk = 1'b0;
   logic              rst;
   logic [1:0]        req_valid, req_ready, rsp_valid;
   logic [127:0]      req_addr;
   logic [63:0]       rsp_data;
   logic              rsp_err, busy;
   ariane_axi::req_t  axi_req;
   ariane_axi::resp_t axi_resp;
   int                total = 0, bad = 0, g;

   always #5 clk = ~clk;

   dma_rd_arbiter #(.NUM_REQ(2), .AXI_ID(1)) dut (
      .clk_i(clk), .rst_i(rst), .req_valid_i(req_valid), .req_addr_i(req_addr),
      .req_ready_o(req_ready), .rsp_valid_o(rsp_valid), .rsp_data_o(rsp_data),
      .rsp_err_o(rsp_err), .busy_o(busy), .axi_req_o(axi_req), .axi_resp_i(axi_resp)
   );

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   initial begin
      rst = 1'b1; req_valid = '0; req_addr = '0; axi_resp = '0;
      #2;
      chk("rst_busy", busy, 0);
      chk("rst_ar_valid", axi_req.ar_valid, 0);
      chk("rst_r_ready", axi_req.r_ready, 0);
      chk("rst_id", axi_req.ar.id, 1);
      chk("rst_size", axi_req.ar.size, 3);
      chk("rst_burst", axi_req.ar.burst, 0);
      chk("rst_addr", axi_req.ar.addr, 0);
      chk("rst_req_ready", req_ready, 0);
      chk("rst_rsp_valid", rsp_valid, 0);
      chk("rst_data", rsp_data, 0);
      chk("rst_err", rsp_err, 0);
      step();
      rst = 1'b0;
      // single request, minimum latency
      req_valid = 2'b01; req_addr[63:0] = 64'h0000_0000_BC00_0000; axi_resp.ar_ready = 1'b1;
      step();
      chk("s_grant", req_ready, 2'b01);
      chk("s_ar_valid", axi_req.ar_valid, 1);
      chk("s_busy", busy, 1);
      chk("s_addr", axi_req.ar.addr, 64'hBC00_0000);
      chk("s_len", axi_req.ar.len, 0);
      chk("s_size", axi_req.ar.size, 3);
      chk("s_burst", axi_req.ar.burst, 1);
      chk("s_id", axi_req.ar.id, 1);
      chk("s_wr_tied", {axi_req.aw_valid, axi_req.w_valid, axi_req.b_ready}, 0);
      req_valid = 2'b00; axi_resp.r_valid = 1'b1; axi_resp.r.data = 64'h55; axi_resp.r.resp = 2'b00;
      step();
      chk("s_r_ar_valid", axi_req.ar_valid, 0);
      chk("s_r_ready", axi_req.r_ready, 1);
      chk("s_grant_pulse", req_ready, 0);
      step();
      chk("s_rsp", rsp_valid, 2'b01);
      chk("s_data", rsp_data, 64'h55);
      chk("s_err", rsp_err, 0);
      chk("s_rsp_r_ready", axi_req.r_ready, 0);
      axi_resp.r_valid = 1'b0;
      step();
      chk("s_idle", busy, 0);
      chk("s_rsp_pulse", rsp_valid, 0);
      chk("s_data_hold", rsp_data, 64'h55);
      rst = 1'b1;
      step();
      rst = 1'b0;
      // round robin with both requesters held
      req_addr = {64'h2000_0000_0000_1008, 64'h1000_0000_0000_0010};
      req_valid = 2'b11; axi_resp.ar_ready = 1'b1; axi_resp.r_valid = 1'b1; axi_resp.r.resp = 2'b00;
      for (int t = 0; t < 4; t++) begin
         g = FIXED ? 0 : t % 2;
         axi_resp.r.data = 64'h1000 + 64'(t);
         step();
         chk("rr_grant", req_ready, 64'(2'b01 << g));
         chk("rr_addr", axi_req.ar.addr, g == 1 ? 64'h2000_0000_0000_1008 : 64'h1000_0000_0000_0010);
         step();
         step();
         chk("rr_rsp", rsp_valid, 64'(2'b01 << g));
         chk("rr_data", rsp_data, 64'h1000 + 64'(t));
         step();
         chk("rr_idle", busy, 0);
      end
      req_valid = 2'b00; axi_resp.r_valid = 1'b0;
      // AR and R backpressure
      req_valid = 2'b01; req_addr[63:0] = 64'h1234_5678_9ABC_DEF0; axi_resp.ar_ready = 1'b0;
      step();
      chk("bp_grant", req_ready, 2'b01);
      req_valid = 2'b00;
      for (int i = 0; i < 6; i++) begin
         chk("bp_ar_valid", axi_req.ar_valid, 1);
         chk("bp_addr", axi_req.ar.addr, 64'h1234_5678_9ABC_DEF0);
         axi_resp.ar_ready = (i == 5);
         step();
      end
      axi_resp.ar_ready = 1'b0;
      chk("bp_ar_drop", axi_req.ar_valid, 0);
      for (int i = 0; i < 10; i++) begin
         chk("bp_r_ready", axi_req.r_ready, 1);
         chk("bp_no_rsp", rsp_valid, 0);
         step();
      end
      axi_resp.r_valid = 1'b1; axi_resp.r.data = 64'hCAFE;
      step();
      chk("bp_rsp", rsp_valid, 2'b01);
      chk("bp_data", rsp_data, 64'hCAFE);
      axi_resp.r_valid = 1'b0;
      step();
      chk("bp_one_pulse", rsp_valid, 0);
      chk("bp_idle", busy, 0);
      // SLVERR response and address alignment
      req_valid = 2'b10; req_addr[127:64] = 64'h0000_0000_BC00_0007; axi_resp.ar_ready = 1'b1;
      step();
      chk("e_grant", req_ready, 2'b10);
      chk("e_addr", axi_req.ar.addr, 64'hBC00_0000);
      req_valid = 2'b00; axi_resp.r_valid = 1'b1; axi_resp.r.data = 64'hDEAD; axi_resp.r.resp = 2'b10;
      step();
      step();
      chk("e_rsp", rsp_valid, 2'b10);
      chk("e_err", rsp_err, 1);
      chk("e_data", rsp_data, 64'hDEAD);
      axi_resp.r_valid = 1'b0; axi_resp.r.resp = 2'b00;
      step();
      chk("e_idle", busy, 0);
      // requester 1 withdraws while requester 0 is in flight
      req_valid = 2'b01; req_addr[63:0] = 64'h3000; axi_resp.ar_ready = 1'b0;
      step();
      chk("w_grant", req_ready, 2'b01);
      req_valid = 2'b10;
      step();
      chk("w_no_grant", req_ready, 0);
      req_valid = 2'b00; axi_resp.ar_ready = 1'b1;
      step();
      chk("w_r_ready", axi_req.r_ready, 1);
      axi_resp.ar_ready = 1'b0; axi_resp.r_valid = 1'b1; axi_resp.r.data = 64'h77;
      step();
      chk("w_rsp", rsp_valid, 2'b01);
      chk("w_data", rsp_data, 64'h77);
      axi_resp.r_valid = 1'b0;
      step();
      chk("w_idle", busy, 0);
      step();
      chk("w_no_grant2", req_ready, 0);
      chk("w_still_idle", busy, 0);
      chk("w_no_rsp", rsp_valid, 0);
      // reset while in R
      req_valid = 2'b10; axi_resp.ar_ready = 1'b1;
      step();
      chk("r_grant", req_ready, 2'b10);
      req_valid = 2'b00;
      step();
      chk("r_in_r", axi_req.r_ready, 1);
      #2 rst = 1'b1;
      #1;
      chk("r_rst_r_ready", axi_req.r_ready, 0);
      chk("r_rst_ar_valid", axi_req.ar_valid, 0);
      chk("r_rst_busy", busy, 0);
      chk("r_rst_data", rsp_data, 0);
      step();
      rst = 1'b0; req_valid = 2'b11;
      step();
      chk("r_ptr_grant", req_ready, 2'b01);
      req_valid = 2'b00; axi_resp.r_valid = 1'b1; axi_resp.r.data = 64'h99;
      step();
      step();
      chk("r_rsp", rsp_valid, 2'b01);
      chk("r_data", rsp_data, 64'h99);
      axi_resp.r_valid = 1'b0;
      step();
      chk("r_idle", busy, 0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
